sram_data_controller: RTL and testbench

- Responder side of the pipeline's MEM-stage data-memory interface.
- Accepts one 32-bit word read or write request (MEM_R / MEM_W style strobes plus ALU-computed byte address) and services it on an external 16-bit asynchronous SRAM as two half-word accesses.
- Its `ready` output drives pipeline freeze: the pipeline stalls while `ready` = 0.
- Data memory starts at byte address 1024.

---
 rtl/sram_data_controller_pkg.sv | 24 ++
 rtl/sram_wait_counter.sv | 29 ++
 rtl/sram_data_controller.sv | 131 +++++++++++++
 tb/tb_sram_data_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_data_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM data controller.
// Holds the FSM encoding, SRAM widths and the byte-address to SRAM-word mapping.
package sram_data_controller_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'd1024;
  localparam int unsigned SramAddrW = 18;
  localparam int unsigned SramDataW = 16;
  localparam int unsigned WordW     = SramAddrW - 1;
  localparam int unsigned CntW      = 4;

  // Addresses below the base wrap modulo 2^32; the byte offset within the word is dropped.
  function automatic logic [WordW-1:0] map_word(input logic [31:0] addr,
                                                input logic [31:0] base);
    return WordW'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts held cycles of one half-word SRAM access.
// tc_o marks the final cycle of the phase (count == WAIT_CYCLES-1).
module sram_wait_counter
  import sram_data_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == CntW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_data_controller.sv
// Services one 32-bit load/store as two half-word accesses on a 16-bit async SRAM.
// ready drives pipeline freeze; all SRAM pins are registered.
module sram_data_controller
  import sram_data_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  output logic [SramAddrW-1:0] sram_addr,
  output logic [SramDataW-1:0] sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SramDataW-1:0] sram_dq_in,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n
);

  state_e               state_q;
  logic                 is_write_q;
  logic [WordW-1:0]     word_q;
  logic [SramDataW-1:0] wdata_hi_q;
  logic [31:0]          rdata_q;
  logic [SramAddrW-1:0] sram_addr_q;
  logic [SramDataW-1:0] sram_dq_out_q;
  logic                 sram_dq_oe_q;
  logic                 sram_we_n_q;
  logic                 sram_oe_n_q;
  logic                 sram_ce_n_q;

  logic             in_phase;
  logic             tc;
  logic             cnt_clear;
  logic [WordW-1:0] req_word;

  assign req_word  = map_word(address, BASE_ADDR);
  assign in_phase  = (state_q == StLow) || (state_q == StHigh);
  assign cnt_clear = (state_q == StIdle) || (in_phase && tc);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear_i(cnt_clear),
    .en_i   (in_phase),
    .tc_o   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      is_write_q    <= 1'b0;
      word_q        <= '0;
      wdata_hi_q    <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_ce_n_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_en || wr_en) begin
            // Simultaneous rd_en/wr_en resolves to a write.
            is_write_q   <= wr_en;
            word_q       <= req_word;
            wdata_hi_q   <= write_data[31:16];
            state_q      <= StLow;
            sram_addr_q  <= {req_word, 1'b0};
            sram_ce_n_q  <= 1'b0;
            sram_we_n_q  <= ~wr_en;
            sram_oe_n_q  <= wr_en;
            sram_dq_oe_q <= wr_en;
            if (wr_en) begin
              sram_dq_out_q <= write_data[15:0];
            end
          end
        end
        StLow: begin
          if (tc) begin
            if (!is_write_q) begin
              rdata_q[15:0] <= sram_dq_in;
            end else begin
              sram_dq_out_q <= wdata_hi_q;
            end
            state_q     <= StHigh;
            sram_addr_q <= {word_q, 1'b1};
          end
        end
        StHigh: begin
          if (tc) begin
            if (!is_write_q) begin
              rdata_q[31:16] <= sram_dq_in;
            end
            state_q      <= StDone;
            sram_ce_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready       = ((state_q == StIdle) && !rd_en && !wr_en) || (state_q == StDone);
  assign read_data   = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_oe_n   = sram_oe_n_q;
  assign sram_ce_n   = sram_ce_n_q;

endmodule

// File: tb/tb_sram_data_controller.sv
// Directed bench for sram_data_controller: one instance at WAIT_CYCLES=2, one at 1,
// each attached to a behavioural 16-bit SRAM.
module tb_sram_data_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0 (WAIT_CYCLES = 2)
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;

  // Instance 1 (WAIT_CYCLES = 1)
  logic        rd_en1, wr_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1, sram_oe_n1, sram_ce_n1;

  sram_data_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n)
  );

  sram_data_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1),
    .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1), .sram_ce_n(sram_ce_n1)
  );

  // Behavioural SRAMs: write sampled at the clock, read combinational.
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem0[sram_addr] <= sram_dq_out;
    if (!sram_ce_n1 && !sram_we_n1 && sram_dq_oe1) mem1[sram_addr1] <= sram_dq_out1;
  end
  assign sram_dq_in  = (!sram_ce_n && !sram_oe_n) ? mem0[sram_addr] : 16'h0;
  assign sram_dq_in1 = (!sram_ce_n1 && !sram_oe_n1) ? mem1[sram_addr1] : 16'h0;

  // Observation mux so one transaction task serves both instances.
  bit          sel_dut;
  logic        m_ready, m_we_n, m_oe_n, m_dq_oe;
  logic [17:0] m_addr;
  logic [31:0] m_rdata;
  assign m_ready = sel_dut ? ready1     : ready;
  assign m_we_n  = sel_dut ? sram_we_n1 : sram_we_n;
  assign m_oe_n  = sel_dut ? sram_oe_n1 : sram_oe_n;
  assign m_dq_oe = sel_dut ? sram_dq_oe1 : sram_dq_oe;
  assign m_addr  = sel_dut ? sram_addr1 : sram_addr;
  assign m_rdata = sel_dut ? read_data1 : read_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd_en1 = r; wr_en1 = w; address1 = a; write_data1 = d;
    end else begin
      rd_en = r; wr_en = w; address = a; write_data = d;
    end
  endtask

  // Issues a request at a falling edge and holds it until ready; cycle 0 is the request cycle.
  task automatic run_req(input bit sel, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d, input int wcyc,
                         output int lat, output int oe_c, output int we_c, output int dqoe_c,
                         output logic [17:0] lo_a, output logic [17:0] hi_a,
                         output logic [31:0] mid_rd);
    @(negedge clk);
    sel_dut = sel;
    drive(sel, r, w, a, d);
    lat = 0; oe_c = 0; we_c = 0; dqoe_c = 0;
    lo_a = 'x; hi_a = 'x; mid_rd = 'x;
    #1;
    while (!m_ready && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!m_oe_n) oe_c++;
      if (!m_we_n) we_c++;
      if (m_dq_oe) dqoe_c++;
      if (lat == 1) lo_a = m_addr;
      if (lat == wcyc + 1) begin
        hi_a   = m_addr;
        mid_rd = m_rdata;
      end
    end
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  typedef struct {
    bit          sel;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [31:0] exp_mid;
    int          exp_lat;
    int          exp_oe;
    int          exp_we;
    int          exp_dqoe;
    logic [17:0] exp_lo;
    logic [17:0] exp_hi;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, oe_c, we_c, dqoe_c, pulses, third_at;
    logic [17:0] lo_a, hi_a;
    logic [31:0] mid_rd;
    logic [15:0] lo_m, hi_m;

    //             sel rd wr addr      data          exp_rd        exp_mid  lat oe we dqoe lo hi
    vecs[0] = '{0, 0, 1, 32'd1024, 32'h0000060A, 32'h00000000, 32'h00000000, 5, 0, 4, 4,
                18'd0, 18'd1};
    vecs[1] = '{0, 1, 0, 32'd1024, 32'h0, 32'h0000060A, 32'h0000060A, 5, 4, 0, 0,
                18'd0, 18'd1};
    vecs[2] = '{0, 0, 1, 32'd1028, 32'hFFFFF9F6, 32'h0000060A, 32'h0000060A, 5, 0, 4, 4,
                18'd2, 18'd3};
    vecs[3] = '{0, 1, 0, 32'd1028, 32'h0, 32'hFFFFF9F6, 32'h0000F9F6, 5, 4, 0, 0,
                18'd2, 18'd3};
    vecs[4] = '{0, 1, 0, 32'd1030, 32'h0, 32'hFFFFF9F6, 32'hFFFFF9F6, 5, 4, 0, 0,
                18'd2, 18'd3};
    vecs[5] = '{0, 1, 1, 32'd1036, 32'h12345678, 32'hFFFFF9F6, 32'hFFFFF9F6, 5, 0, 4, 4,
                18'd6, 18'd7};
    vecs[6] = '{0, 1, 0, 32'd1036, 32'h0, 32'h12345678, 32'hFFFF5678, 5, 4, 0, 0,
                18'd6, 18'd7};
    vecs[7] = '{0, 1, 0, 32'd1020, 32'h0, 32'hCAFEBEEF, 32'h1234BEEF, 5, 4, 0, 0,
                18'h3FFFE, 18'h3FFFF};
    vecs[8] = '{1, 1, 0, 32'd1036, 32'h0, 32'hF00D0BAD, 32'h00000BAD, 3, 2, 0, 0,
                18'd6, 18'd7};
    vecs[9] = '{1, 1, 1, 32'd1036, 32'h12345678, 32'hF00D0BAD, 32'hF00D0BAD, 3, 0, 2, 2,
                18'd6, 18'd7};

    mem0[18'h3FFFE] <= 16'hBEEF;
    mem0[18'h3FFFF] <= 16'hCAFE;
    mem1[18'd6]     <= 16'h0BAD;
    mem1[18'd7]     <= 16'hF00D;

    rst = 1'b1;
    sel_dut = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset ready", {31'h0, ready}, 32'd1);
    check("reset ce_n", {31'h0, sram_ce_n}, 32'd1);
    check("reset we_n", {31'h0, sram_we_n}, 32'd1);
    check("reset oe_n", {31'h0, sram_oe_n}, 32'd1);
    check("reset dq_oe", {31'h0, sram_dq_oe}, 32'd0);
    check("reset sram_addr", {14'h0, sram_addr}, 32'd0);
    check("reset dq_out", {16'h0, sram_dq_out}, 32'd0);
    check("reset read_data", read_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].sel ? 1 : 2, lat, oe_c, we_c, dqoe_c, lo_a, hi_a, mid_rd);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d read_data", i), m_rdata, vecs[i].exp_rd);
      check($sformatf("v%0d mid read_data", i), mid_rd, vecs[i].exp_mid);
      check($sformatf("v%0d oe_n low cycles", i), oe_c, vecs[i].exp_oe);
      check($sformatf("v%0d we_n low cycles", i), we_c, vecs[i].exp_we);
      check($sformatf("v%0d dq_oe cycles", i), dqoe_c, vecs[i].exp_dqoe);
      check($sformatf("v%0d low addr", i), {14'h0, lo_a}, {14'h0, vecs[i].exp_lo});
      check($sformatf("v%0d high addr", i), {14'h0, hi_a}, {14'h0, vecs[i].exp_hi});
      if (vecs[i].wr) begin
        lo_m = vecs[i].sel ? mem1[vecs[i].exp_lo] : mem0[vecs[i].exp_lo];
        hi_m = vecs[i].sel ? mem1[vecs[i].exp_hi] : mem0[vecs[i].exp_hi];
        check($sformatf("v%0d mem low", i), {16'h0, lo_m}, {16'h0, vecs[i].data[15:0]});
        check($sformatf("v%0d mem high", i), {16'h0, hi_m}, {16'h0, vecs[i].data[31:16]});
      end
    end

    // Back-to-back held stores; the address advances when ready is seen in DONE.
    sel_dut = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'hA0A0B0B1);
    pulses = 0; we_c = 0; third_at = -1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (!sram_we_n) we_c++;
      if (ready && wr_en) begin
        pulses++;
        if (pulses == 1) drive(1'b0, 1'b0, 1'b1, 32'd1028, 32'hC0C0D0D1);
        else if (pulses == 2) drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'hE0E0F0F1);
        else begin
          third_at = c;
          drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
    end
    check("b2b ready pulses", pulses, 3);
    check("b2b third done cycle", third_at, 17);
    check("b2b we_n low cycles", we_c, 12);
    check("b2b mem0", {16'h0, mem0[0]}, 32'h0000B0B1);
    check("b2b mem1", {16'h0, mem0[1]}, 32'h0000A0A0);
    check("b2b mem2", {16'h0, mem0[2]}, 32'h0000D0D1);
    check("b2b mem3", {16'h0, mem0[3]}, 32'h0000C0C0);
    check("b2b mem4", {16'h0, mem0[4]}, 32'h0000F0F1);
    check("b2b mem5", {16'h0, mem0[5]}, 32'h0000E0E0);

    // Reset during the HIGH phase of a write.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'hAAAA5555);
    repeat (3) @(negedge clk);
    check("rst-test high addr", {14'h0, sram_addr}, 32'd9);
    check("rst-test we_n before", {31'h0, sram_we_n}, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst-test ce_n", {31'h0, sram_ce_n}, 32'd1);
    check("rst-test we_n", {31'h0, sram_we_n}, 32'd1);
    check("rst-test oe_n", {31'h0, sram_oe_n}, 32'd1);
    check("rst-test dq_oe", {31'h0, sram_dq_oe}, 32'd0);
    check("rst-test read_data", read_data, 32'd0);
    check("rst-test ready", {31'h0, ready}, 32'd1);
    check("rst-test mem low half", {16'h0, mem0[8]}, 32'h00005555);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst idle ready", {31'h0, ready}, 32'd1);
    check("post-rst idle ce_n", {31'h0, sram_ce_n}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
